// File: rtl/sincos_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : sincos_pipelined
// Brief    : Fully pipelined rotation-mode CORDIC, (mag, angle) -> (mag*cos, mag*sin).
// Revision : 1.0 - initial release
// ============================================================================
module sincos_pipelined #(
    parameter int BITS_HIGH  = 16,
    parameter int BITS_LOW   = 16,
    parameter int IS_IBNIZ   = 0,
    parameter int BITS_GUARD = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic                          ivalid,
    input  logic [BITS_HIGH+BITS_LOW-1:0] angle,
    input  logic [BITS_HIGH+BITS_LOW-1:0] mag,
    output logic                          ovalid,
    output logic [BITS_HIGH+BITS_LOW-1:0] ocos,
    output logic [BITS_HIGH+BITS_LOW-1:0] osin,
    output logic                          orange_err
);

    localparam int  c_w    = BITS_HIGH + BITS_LOW;
    localparam int  c_iw   = c_w + BITS_GUARD + 1;
    localparam int  c_frac = BITS_LOW + BITS_GUARD;
    localparam int  c_pw   = c_w + c_iw;
    localparam real c_pi_r = 3.14159265358979323846;

    function automatic logic signed [c_iw-1:0] to_fix(input real v, input int frac);
        real s;
        s = 1.0;
        for (int k = 0; k < frac; k++) s = s * 2.0;
        return c_iw'(longint'(v * s));
    endfunction

    // atan(2^-i) by Taylor series; argument is at most 0.5 beyond i=0
    function automatic real atan_pow2(input int i);
        real x, term, sum;
        if (i == 0) return c_pi_r / 4.0;
        x = 1.0;
        for (int k = 0; k < i; k++) x = x / 2.0;
        sum  = 0.0;
        term = x;
        for (int n = 0; n < 40; n++) begin
            sum  = ((n % 2) == 0) ? sum + term / (2 * n + 1) : sum - term / (2 * n + 1);
            term = term * x * x;
        end
        return sum;
    endfunction

    localparam logic signed [c_iw-1:0] c_k       = to_fix(0.6072529350, c_frac);
    localparam logic signed [c_iw-1:0] c_half    = to_fix((IS_IBNIZ != 0) ? 0.5  : c_pi_r,       c_frac);
    localparam logic signed [c_iw-1:0] c_quarter = to_fix((IS_IBNIZ != 0) ? 0.25 : c_pi_r / 2.0, c_frac);
    localparam logic signed [c_iw-1:0] c_pi_lim  = to_fix(c_pi_r, BITS_LOW);

    logic signed [c_iw-1:0] r_x [0:BITS_LOW];
    logic signed [c_iw-1:0] r_y [0:BITS_LOW];
    logic signed [c_iw-1:0] r_z [0:BITS_LOW];
    logic                   r_v [0:BITS_LOW];
    logic                   r_e [0:BITS_LOW];

    logic signed [c_iw-1:0] w_ang_ext;
    logic signed [c_iw-1:0] w_z_in;
    logic signed [c_iw-1:0] w_z0;
    logic signed [c_iw-1:0] w_x_k;
    logic signed [c_iw-1:0] w_x0;
    logic signed [c_pw-1:0] w_prod;
    logic                   w_fold_pos;
    logic                   w_fold_neg;
    logic                   w_err;
    logic                   w_unused;

    assign w_ang_ext = c_iw'($signed(angle));

    generate
        if (IS_IBNIZ != 0) begin : g_turns
            // Only the fractional bits matter: the angle wraps modulo one turn
            assign w_z_in = c_iw'($signed(angle[BITS_LOW-1:0])) <<< BITS_GUARD;
            assign w_err  = 1'b0;
        end else begin : g_radians
            assign w_z_in = w_ang_ext <<< BITS_GUARD;
            assign w_err  = (w_ang_ext > c_pi_lim) || (w_ang_ext < -c_pi_lim);
        end
    endgenerate

    always_comb begin
        w_prod     = c_pw'($signed(mag)) * c_pw'(c_k);
        w_x_k      = w_prod[BITS_LOW +: c_iw];
        w_fold_pos = (w_z_in > c_quarter);
        w_fold_neg = (w_z_in < -c_quarter);
        w_z0       = w_z_in;
        w_x0       = w_x_k;
        if (w_fold_pos) begin
            w_z0 = w_z_in - c_half;
            w_x0 = -w_x_k;
        end else if (w_fold_neg) begin
            w_z0 = w_z_in + c_half;
            w_x0 = -w_x_k;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x[0] <= '0;
            r_y[0] <= '0;
            r_z[0] <= '0;
            r_v[0] <= 1'b0;
            r_e[0] <= 1'b0;
        end else if (ce) begin
            r_x[0] <= w_x0;
            r_y[0] <= '0;
            r_z[0] <= w_z0;
            r_v[0] <= ivalid;
            r_e[0] <= w_err;
        end
    end

    generate
        for (genvar i = 0; i < BITS_LOW; i++) begin : g_iter
            localparam logic signed [c_iw-1:0] c_atan =
                to_fix((IS_IBNIZ != 0) ? atan_pow2(i) / (2.0 * c_pi_r) : atan_pow2(i), c_frac);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_x[i+1] <= '0;
                    r_y[i+1] <= '0;
                    r_z[i+1] <= '0;
                    r_v[i+1] <= 1'b0;
                    r_e[i+1] <= 1'b0;
                end else if (ce) begin
                    if (!r_z[i][c_iw-1]) begin
                        r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
                        r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
                        r_z[i+1] <= r_z[i] - c_atan;
                    end else begin
                        r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
                        r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
                        r_z[i+1] <= r_z[i] + c_atan;
                    end
                    r_v[i+1] <= r_v[i];
                    r_e[i+1] <= r_e[i];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid     <= 1'b0;
            orange_err <= 1'b0;
            ocos       <= '0;
            osin       <= '0;
        end else if (ce) begin
            ovalid     <= r_v[BITS_LOW];
            orange_err <= r_e[BITS_LOW];
            ocos       <= r_x[BITS_LOW][BITS_GUARD +: c_w];
            osin       <= r_y[BITS_LOW][BITS_GUARD +: c_w];
        end
    end

    // Guard/sign bits, residual angle and product tails are intentionally dropped
    assign w_unused = ^{w_prod, w_ang_ext, r_x[BITS_LOW], r_y[BITS_LOW], r_z[BITS_LOW]};

endmodule
`default_nettype wire

// File: tb/tb_sincos_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_sincos_pipelined
// Brief    : Directed-vector bench for sincos_pipelined (radians and turns builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sincos_pipelined;

    localparam int NV  = 13;
    localparam int LAT = 18;

    logic        clk = 1'b0;
    logic        rst, ce, ivalid;
    logic [31:0] angle, mag;
    logic        ovalid_a, oerr_a, ovalid_b, oerr_b;
    logic [31:0] ocos_a, osin_a, ocos_b, osin_b;

    always #5 clk = ~clk;

    sincos_pipelined #(.BITS_HIGH(16), .BITS_LOW(16), .IS_IBNIZ(0), .BITS_GUARD(2)) u_dut_rad (
        .clk(clk), .rst(rst), .ce(ce), .ivalid(ivalid), .angle(angle), .mag(mag),
        .ovalid(ovalid_a), .ocos(ocos_a), .osin(osin_a), .orange_err(oerr_a)
    );

    sincos_pipelined #(.BITS_HIGH(16), .BITS_LOW(16), .IS_IBNIZ(1), .BITS_GUARD(2)) u_dut_turn (
        .clk(clk), .rst(rst), .ce(ce), .ivalid(ivalid), .angle(angle), .mag(mag),
        .ovalid(ovalid_b), .ocos(ocos_b), .osin(osin_b), .orange_err(oerr_b)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    int  ce_edges = 0;
    bit  exp_ov   = 1'b0;
    int  q_idx[$];
    int  q_due[$];
    int  v_mag[NV], v_ang[NV], v_cos[NV], v_sin[NV];
    bit  v_err[NV];

    task automatic check(input string tag, input longint obs, input longint exp, input int tol);
        n_checks++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
        end
    endtask

    // Drive one clock of stimulus, then compare radians-build outputs against the expectation queue
    task automatic step(input bit r, input bit c, input bit v, input int idx);
        rst    = r;
        ce     = c;
        ivalid = v;
        mag    = v_mag[idx];
        angle  = v_ang[idx];
        @(posedge clk);
        #1;
        if (r) begin
            q_idx.delete();
            q_due.delete();
            exp_ov = 1'b0;
            check("rst_ovalid", ovalid_a, 0, 0);
            check("rst_err",    oerr_a,   0, 0);
            check("rst_cos",    longint'($signed(ocos_a)), 0, 0);
            check("rst_sin",    longint'($signed(osin_a)), 0, 0);
        end else if (c) begin
            ce_edges++;
            if (v) begin
                q_idx.push_back(idx);
                q_due.push_back(ce_edges + LAT - 1);
            end
            if (q_due.size() > 0 && q_due[0] == ce_edges) begin
                exp_ov = 1'b1;
                check("out_ovalid", ovalid_a, 1, 0);
                check("out_err",    oerr_a, v_err[q_idx[0]], 0);
                if (!v_err[q_idx[0]]) begin
                    check("out_cos", longint'($signed(ocos_a)), v_cos[q_idx[0]], 4);
                    check("out_sin", longint'($signed(osin_a)), v_sin[q_idx[0]], 4);
                end
                void'(q_idx.pop_front());
                void'(q_due.pop_front());
            end else begin
                exp_ov = 1'b0;
                check("bubble_ovalid", ovalid_a, 0, 0);
            end
        end else begin
            check("hold_ovalid", ovalid_a, exp_ov, 0);
        end
    endtask

    initial begin
        int k, guard;
        bit c;
        v_mag = '{65536, 65536, 65536, 65536, 65536, 32768, 65536, 65536, 65536, 65536, 65536, -32768, 0};
        v_ang = '{0, 102943, -205887, -102943, 34315, -68629, 154416, 205887, 147456, 262144, 205888, 51472, 51472};
        v_cos = '{65536, 0, -65536, 0, 56756, 16384, -46341, -65536, -41168, 0, 0, -23170, 0};
        v_sin = '{0, 65536, 0, -65536, 32768, -28378, 46341, 0, 50992, 0, 0, -23170, 0};
        v_err = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

        // Reset with ce low and a valid input that must be discarded
        step(1'b1, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b1, 0);

        // Directed vectors back to back, then drain
        for (int i = 0; i < NV; i++) step(1'b0, 1'b1, 1'b1, i);
        repeat (LAT) step(1'b0, 1'b1, 1'b0, 0);

        // Turns build: 2.25 turns then 4.0 turns
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 8);
        step(1'b0, 1'b1, 1'b1, 9);
        repeat (LAT - 3) step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        check("turn1_ovalid", ovalid_b, 1, 0);
        check("turn1_err",    oerr_b, 0, 0);
        check("turn1_cos",    longint'($signed(ocos_b)), 0, 4);
        check("turn1_sin",    longint'($signed(osin_b)), 65536, 4);
        step(1'b0, 1'b1, 1'b0, 0);
        check("turn2_ovalid", ovalid_b, 1, 0);
        check("turn2_err",    oerr_b, 0, 0);
        check("turn2_cos",    longint'($signed(ocos_b)), 65536, 4);
        check("turn2_sin",    longint'($signed(osin_b)), 0, 4);
        step(1'b0, 1'b1, 1'b0, 0);
        check("turn3_ovalid", ovalid_b, 0, 0);

        // 30 back-to-back samples under a random ce pattern (~30% low)
        k = 0;
        guard = 0;
        while (k < 30 && guard < 400) begin
            c = ($urandom_range(0, 99) >= 30);
            step(1'b0, c, 1'b1, k % NV);
            if (c) k++;
            guard++;
        end
        check("stream_sent", k, 30, 0);
        guard = 0;
        while (q_due.size() > 0 && guard < 300) begin
            c = ($urandom_range(0, 99) >= 30);
            step(1'b0, c, 1'b0, 0);
            guard++;
        end
        check("stream_drain", q_due.size(), 0, 0);

        // Mid-flight reset with 10 samples in the pipe, then one new sample
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, i);
        step(1'b1, 1'b1, 1'b1, 4);
        step(1'b0, 1'b1, 1'b1, 1);
        repeat (LAT + 4) step(1'b0, 1'b1, 1'b0, 0);
        check("final_drain", q_due.size(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
